sgd_ab_dispatcher: RTL and testbench

Synthesizable front end that streams bit-sliced A cache lines and B label lines from the memory read path into the per-engine A dispatch FIFOs and the shared B dispatch FIFO of sgd_top_bw.
Generalises fixed single-engine feeding in four ways:
- ENGINE_NUM engines, with bit-plane-group round-robin routing.
- Per-engine almost_full backpressure.
- Epoch repetition.
- Explicit done.
Sits between the HBM/DMA read-response streams and the sgd_top_bw dispatch ports.

---
 rtl/sgd_dispatch_pkg.sv | 24 ++
 rtl/sgd_dispatch_route.sv | 34 +++
 rtl/sgd_ab_dispatcher.sv | 135 +++++++++++++
 tb/tb_sgd_ab_dispatcher.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sgd_dispatch_pkg.sv
// Shared types and constants for the SGD A/B dispatch front end.
package sgd_dispatch_pkg;

    localparam int NUM_OF_BANKS      = 8;
    localparam int NUM_BITS_PER_BANK = 64;
    localparam int A_W_DEF           = NUM_BITS_PER_BANK * NUM_OF_BANKS;
    localparam int B_W_DEF           = 32 * NUM_OF_BANKS;
    localparam int MAX_BITS          = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_EPOCH_END,
        S_DONE
    } state_t;

    // A zero plane count would never advance the engine, so it is treated as one.
    function automatic logic [5:0] clamp_bits(input logic [5:0] nb);
        if (nb == 6'd0) return 6'd1;
        if (nb > 6'(MAX_BITS)) return 6'(MAX_BITS);
        return nb;
    endfunction

endpackage

// File: rtl/sgd_dispatch_route.sv
// Bit-plane-group round-robin: every nbits accepted A lines move to the next engine.
module sgd_dispatch_route
    import sgd_dispatch_pkg::*;
#(
    parameter int ENGINE_NUM = 8,
    parameter int ENG_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             clear,
    input  logic [5:0]       nbits,
    output logic [ENG_W-1:0] eng_sel
);

    localparam logic [ENG_W-1:0] ENG_LAST = ENG_W'(ENGINE_NUM - 1);

    logic [$clog2(MAX_BITS):0] bit_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            bit_cnt <= '0;
            eng_sel <= '0;
        end else if (advance) begin
            if (bit_cnt == nbits - 6'd1) begin
                bit_cnt <= '0;
                eng_sel <= (eng_sel == ENG_LAST) ? '0 : eng_sel + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sgd_ab_dispatcher.sv
// Streams A lines to per-engine dispatch FIFOs and B lines to the shared B FIFO,
// repeating for a latched number of epochs and pulsing done at the end.
module sgd_ab_dispatcher
    import sgd_dispatch_pkg::*;
#(
    parameter int ENGINE_NUM = 8,
    parameter int A_W        = A_W_DEF,
    parameter int B_W        = B_W_DEF,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [5:0]                number_of_bits,
    input  logic [CNT_W-1:0]          number_of_epochs,
    input  logic [CNT_W-1:0]          a_lines_per_epoch,
    input  logic [CNT_W-1:0]          b_lines_per_epoch,
    input  logic [A_W-1:0]            a_in_data,
    input  logic                      a_in_valid,
    output logic                      a_in_ready,
    input  logic [B_W-1:0]            b_in_data,
    input  logic                      b_in_valid,
    output logic                      b_in_ready,
    output logic [ENGINE_NUM*A_W-1:0] dispatch_axb_a_data,
    output logic [ENGINE_NUM-1:0]     dispatch_axb_a_wr_en,
    input  logic [ENGINE_NUM-1:0]     dispatch_axb_a_almost_full,
    output logic [B_W-1:0]            dispatch_axb_b_data,
    output logic                      dispatch_axb_b_wr_en,
    input  logic                      dispatch_axb_b_almost_full,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          epoch_cnt
);

    localparam int ENG_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;

    state_t                         state;
    logic [5:0]                     nbits_q;
    logic [CNT_W-1:0]               epochs_q, a_lines_q, b_lines_q;
    logic [CNT_W-1:0]               a_rem, b_rem;
    logic [ENG_W-1:0]               eng_sel;
    logic [ENGINE_NUM-1:0][A_W-1:0] a_data_q;
    logic                           a_fire, b_fire, start_ok, reload;

    assign a_in_ready = (state == S_RUN) && (a_rem != '0) && !dispatch_axb_a_almost_full[eng_sel];
    assign b_in_ready = (state == S_RUN) && (b_rem != '0) && !dispatch_axb_b_almost_full;
    assign a_fire     = a_in_valid && a_in_ready;
    assign b_fire     = b_in_valid && b_in_ready;
    assign start_ok   = (state == S_IDLE) && start;
    assign reload     = (state == S_EPOCH_END) && (epoch_cnt + CNT_W'(1) != epochs_q);
    assign busy       = (state == S_RUN) || (state == S_EPOCH_END);

    assign dispatch_axb_a_data = a_data_q;

    sgd_dispatch_route #(
        .ENGINE_NUM (ENGINE_NUM),
        .ENG_W      (ENG_W)
    ) u_route (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (a_fire),
        .clear   (start_ok || reload),
        .nbits   (nbits_q),
        .eng_sel (eng_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            nbits_q   <= '0;
            epochs_q  <= '0;
            a_lines_q <= '0;
            b_lines_q <= '0;
            a_rem     <= '0;
            b_rem     <= '0;
            epoch_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    nbits_q   <= clamp_bits(number_of_bits);
                    epochs_q  <= number_of_epochs;
                    a_lines_q <= a_lines_per_epoch;
                    b_lines_q <= b_lines_per_epoch;
                    a_rem     <= a_lines_per_epoch;
                    b_rem     <= b_lines_per_epoch;
                    epoch_cnt <= '0;
                    state     <= (number_of_epochs != '0 &&
                                  (a_lines_per_epoch != '0 || b_lines_per_epoch != '0))
                                 ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    if (a_fire) a_rem <= a_rem - 1'b1;
                    if (b_fire) b_rem <= b_rem - 1'b1;
                    if (a_rem == '0 && b_rem == '0) state <= S_EPOCH_END;
                end
                S_EPOCH_END: begin
                    epoch_cnt <= epoch_cnt + 1'b1;
                    if (reload) begin
                        a_rem <= a_lines_q;
                        b_rem <= b_lines_q;
                        state <= S_RUN;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered output stage; engines not written this cycle keep their last line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_data_q             <= '0;
            dispatch_axb_a_wr_en <= '0;
            dispatch_axb_b_data  <= '0;
            dispatch_axb_b_wr_en <= 1'b0;
        end else begin
            dispatch_axb_a_wr_en <= '0;
            dispatch_axb_b_wr_en <= b_fire;
            if (a_fire) begin
                dispatch_axb_a_wr_en[eng_sel] <= 1'b1;
                a_data_q[eng_sel]             <= a_in_data;
            end
            if (b_fire) dispatch_axb_b_data <= b_in_data;
        end
    end

endmodule

// File: tb/tb_sgd_ab_dispatcher.sv
// Scoreboard bench: the driver pushes the expected engine/data per accepted line,
// a negedge monitor pops and compares on every dispatch write.
module tb_sgd_ab_dispatcher;

    localparam int E  = 2;
    localparam int AW = 32;
    localparam int BW = 16;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [5:0]      number_of_bits = '0;
    logic [CW-1:0]   number_of_epochs = '0, a_lines_per_epoch = '0, b_lines_per_epoch = '0;
    logic [AW-1:0]   a_in_data = '0;
    logic            a_in_valid = 1'b0;
    logic            a_in_ready;
    logic [BW-1:0]   b_in_data = '0;
    logic            b_in_valid = 1'b0;
    logic            b_in_ready;
    logic [E*AW-1:0] a_data;
    logic [E-1:0]    a_wr_en;
    logic [E-1:0]    a_af = '0;
    logic [BW-1:0]   b_data;
    logic            b_wr_en;
    logic            b_af = 1'b0;
    logic            busy, done;
    logic [CW-1:0]   epoch_cnt;

    sgd_ab_dispatcher #(.ENGINE_NUM(E), .A_W(AW), .B_W(BW), .CNT_W(CW)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .start                      (start),
        .number_of_bits             (number_of_bits),
        .number_of_epochs           (number_of_epochs),
        .a_lines_per_epoch          (a_lines_per_epoch),
        .b_lines_per_epoch          (b_lines_per_epoch),
        .a_in_data                  (a_in_data),
        .a_in_valid                 (a_in_valid),
        .a_in_ready                 (a_in_ready),
        .b_in_data                  (b_in_data),
        .b_in_valid                 (b_in_valid),
        .b_in_ready                 (b_in_ready),
        .dispatch_axb_a_data        (a_data),
        .dispatch_axb_a_wr_en       (a_wr_en),
        .dispatch_axb_a_almost_full (a_af),
        .dispatch_axb_b_data        (b_data),
        .dispatch_axb_b_wr_en       (b_wr_en),
        .dispatch_axb_b_almost_full (b_af),
        .busy                       (busy),
        .done                       (done),
        .epoch_cnt                  (epoch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            eng;
        logic [AW-1:0] data;
    } a_exp_t;

    a_exp_t        qa[$];
    logic [BW-1:0] qb[$];
    int checks = 0, errors = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int eng_of(input int g, input int al, input int ne);
        if (al == 0) return 0;
        return ((g % al) / ne) % E;
    endfunction

    always @(negedge clk) begin
        a_exp_t x;
        logic [BW-1:0] y;
        for (int e = 0; e < E; e++) begin
            if (a_wr_en[e]) begin
                chk("a_write_expected", 64'(qa.size() != 0), 1);
                if (qa.size() != 0) begin
                    x = qa.pop_front();
                    chk("a_engine", 64'(e), 64'(x.eng));
                    chk("a_data", a_data[e*AW +: AW], x.data);
                end
            end
        end
        if (b_wr_en) begin
            chk("b_write_expected", 64'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                y = qb.pop_front();
                chk("b_data", b_data, y);
            end
        end
        if (done) done_cnt++;
    end

    task automatic run_job(input int nb, input int ep, input int al, input int bl,
                           input bit bp, input bit dup, input int abort_at, input int exp_cyc);
        int ne, tot_a, tot_b, ga, gb, cyc, d0, bp_left;
        bit fin, abort_now, bp_armed;
        ne        = (nb == 0) ? 1 : ((nb > 32) ? 32 : nb);
        tot_a     = (ep == 0 || (al == 0 && bl == 0)) ? 0 : ep * al;
        tot_b     = (ep == 0 || (al == 0 && bl == 0)) ? 0 : ep * bl;
        ga = 0; gb = 0; cyc = 0; bp_left = 0;
        fin = 1'b0; abort_now = 1'b0; bp_armed = bp;
        d0 = done_cnt;
        @(negedge clk);
        number_of_bits    = 6'(nb);
        number_of_epochs  = CW'(ep);
        a_lines_per_epoch = CW'(al);
        b_lines_per_epoch = CW'(bl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 4000) begin
            if (abort_now) begin
                rst_n = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0; a_af = '0;
                @(negedge clk);
                chk("abort_a_wr_en", 64'(a_wr_en), 0);
                chk("abort_b_wr_en", 64'(b_wr_en), 0);
                chk("abort_busy", 64'(busy), 0);
                chk("abort_epoch_cnt", epoch_cnt, 0);
                chk("abort_queue_drained", 64'(qa.size() + qb.size()), 0);
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                fin = 1'b1;
            end else begin
                start = dup && (cyc == 5);
                if (dup && cyc == 5) begin
                    number_of_epochs = 7; a_lines_per_epoch = 3; number_of_bits = 1;
                end
                a_af = (bp_left > 0) ? 2'b10 : 2'b00;
                if (bp_left > 0) bp_left--;
                a_in_valid = (ga < tot_a);
                a_in_data  = AW'(32'hA000_0000 + ga);
                b_in_valid = (gb < tot_b) && (!bp || (cyc % 2 == 0));
                b_in_data  = BW'(16'hB000 + gb);
                #1;
                if (a_af[1] && a_in_valid && eng_of(ga, al, ne) == 1)
                    chk("bp_a_ready_low", 64'(a_in_ready), 0);
                if (a_af != '0 && b_in_valid)
                    chk("bp_b_ready_high", 64'(b_in_ready), 1);
                if (a_in_valid && a_in_ready) begin
                    qa.push_back('{eng_of(ga, al, ne), a_in_data});
                    ga++;
                    if (bp_armed && ga == 9) begin bp_left = 10; bp_armed = 1'b0; end
                    if (abort_at > 0 && ga == abort_at) abort_now = 1'b1;
                end
                if (b_in_valid && b_in_ready) begin
                    qb.push_back(b_in_data);
                    gb++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0; a_af = '0;
        chk("job_finished", 64'(fin), 1);
        if (exp_cyc >= 0) chk("done_latency", 64'(cyc), 64'(exp_cyc));
        chk("a_lines_sent", 64'(ga), 64'(tot_a));
        chk("b_lines_sent", 64'(gb), 64'(tot_b));
        @(negedge clk);
        chk("done_pulse_count", 64'(done_cnt - d0), 1);
        chk("done_one_cycle", 64'(done), 0);
        chk("busy_idle", 64'(busy), 0);
        chk("epoch_cnt", epoch_cnt, (tot_a + tot_b == 0) ? 0 : 64'(ep));
        chk("queues_drained", 64'(qa.size() + qb.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_wr_en", 64'(a_wr_en), 0);
        chk("rst_b_wr_en", 64'(b_wr_en), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_epoch_cnt", epoch_cnt, 0);
        chk("rst_a_ready", 64'(a_in_ready), 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", 64'(b_data), 0);
        rst_n = 1'b1;

        run_job(8, 1, 32, 4,  1'b0, 1'b0, 0, -1);   // routing
        run_job(8, 1, 32, 16, 1'b1, 1'b0, 0, -1);   // backpressure on engine 1
        run_job(8, 3, 16, 2,  1'b0, 1'b0, 0, -1);   // epochs
        run_job(8, 2, 12, 1,  1'b0, 1'b0, 0, -1);   // eng_sel restarts each epoch
        run_job(8, 0, 16, 2,  1'b0, 1'b0, 0, 1);    // zero epochs
        run_job(8, 1, 0, 0,   1'b0, 1'b0, 0, 1);    // zero lines
        run_job(0, 1, 6, 0,   1'b0, 1'b0, 0, -1);   // nbits 0 acts as 1
        run_job(40, 1, 8, 1,  1'b0, 1'b0, 0, -1);   // nbits clamped to 32
        run_job(8, 1, 32, 4,  1'b0, 1'b0, 10, -1);  // reset after 10 A lines
        run_job(8, 1, 32, 4,  1'b0, 1'b0, 0, -1);   // fresh replay
        run_job(4, 2, 16, 3,  1'b0, 1'b1, 0, -1);   // start while busy ignored

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
